// File: rtl/hilo_muldiv.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide, 32 iterations plus a FINISH cycle.
module hilo_muldiv (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  input  logic        flush,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_b;
  logic        r_is_div, r_sign_q, r_sign_r, r_dz;
  logic [31:0] r_hi, r_lo;
  logic        r_done;

  logic        w_accept, w_signed;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_top;
  logic [33:0] w_div_diff;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_signed = ~op[0];
  assign w_abs_a  = (w_signed && RD1[31]) ? -RD1 : RD1;
  assign w_abs_b  = (w_signed && RD2[31]) ? -RD2 : RD2;

  // Multiply: low half of r_acc holds the multiplier, shifted out as the product grows in.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  // Divide: r_acc = {remainder, dividend/quotient}; shifted remainder needs 33 bits.
  assign w_div_top  = r_acc[63:31];
  assign w_div_diff = {1'b0, w_div_top} - {2'b00, r_b};

  assign w_prod = r_sign_q ? -r_acc : r_acc;
  assign w_quo  = r_sign_q ? -r_acc[31:0]  : r_acc[31:0];
  assign w_rem  = r_sign_r ? -r_acc[63:32] : r_acc[63:32];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (op == OP_MULT || op == OP_MULTU)     w_next = S_MUL;
          else if (op == OP_DIV || op == OP_DIVU)  w_next = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (flush)              w_next = S_IDLE;
        else if (r_cnt == 5'd31) w_next = S_FINISH;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_done   <= 1'b0;
      r_acc    <= 64'd0;
      r_b      <= 32'd0;
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              OP_MTHI: r_hi <= RD1;
              OP_MTLO: r_lo <= RD1;
              OP_MULT, OP_MULTU: begin
                r_acc    <= {32'd0, w_abs_b};
                r_b      <= w_abs_a;
                r_sign_q <= w_signed & (RD1[31] ^ RD2[31]);
                r_sign_r <= 1'b0;
                r_is_div <= 1'b0;
                r_dz     <= 1'b0;
                r_cnt    <= 5'd0;
              end
              OP_DIV, OP_DIVU: begin
                r_acc    <= {32'd0, w_abs_a};
                r_b      <= w_abs_b;
                r_sign_q <= w_signed & (RD1[31] ^ RD2[31]);
                r_sign_r <= w_signed & RD1[31];
                r_is_div <= 1'b1;
                r_dz     <= (RD2 == 32'd0);
                r_cnt    <= 5'd0;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (!flush) begin
            r_acc <= {w_mul_sum, r_acc[31:1]};
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_DIV: begin
          if (!flush) begin
            if (!w_div_diff[33]) r_acc <= {w_div_diff[31:0], r_acc[30:0], 1'b1};
            else                 r_acc <= {r_acc[62:0], 1'b0};
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_FINISH: begin
          if (!flush) begin
            r_done <= 1'b1;
            if (!r_is_div) begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end else if (!r_dz) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign HI   = r_hi;
  assign LO   = r_lo;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit with the architectural HI/LO register pair. It sits alongside the execute stage of the pipeline. The ID stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO operations to it using the same RD1/RD2 operands the ALU sees. Its HI/LO outputs drive the execute stage's HI and LO inputs. While an operation is in flight it asserts `busy`, so the hazard logic can stall instructions that read HI/LO.

## Interface
Parameters:
- none (datapath fixed at 32 bits; 64-bit product/remainder-quotient internal)

Ports:
- `clk_in`  in  1  single clock; all state updates on rising edge
- `rst_in`  in  1  reset, asynchronous, active-high
- `start`  in  1  issue strobe; sampled only in IDLE
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 ignored
- `RD1`  in  32  operand A (multiplicand / dividend / MTHI-MTLO source)
- `RD2`  in  32  operand B (multiplier / divisor)
- `flush`  in  1  abort in-flight mul/div (pipeline squash)
- `HI`  out  32  HI register (remainder / upper product)
- `LO`  out  32  LO register (quotient / lower product)
- `busy`  out  1  mul/div in progress
- `done`  out  1  one-cycle pulse after HI/LO written by mul/div

## Operation
- Reset: HI=0, LO=0, busy=0, done=0, state IDLE. Assertion mid-operation aborts immediately; partial results discarded.
- States: IDLE, MUL, DIV, FINISH.
- IDLE, start=1:
  - MTHI: HI<=RD1 at that edge.
  - MTLO: LO<=RD1 at that edge.
  - MULT/MULTU: latch |A|, |B| (signed) or raw values (unsigned), and sign = A[31]^B[31] (signed only). Go to MUL, iteration counter = 0.
  - DIV/DIVU: latch as above, with quotient sign = A[31]^B[31] and remainder sign = A[31]. Record divide-by-zero flag if RD2==0. Go to DIV.
  - Codes 110/111: no effect.
- MUL: radix-2 shift-add, one bit per cycle, 32 cycles, then FINISH.
- DIV: restoring division, one quotient bit per cycle, 32 cycles, then FINISH.
- FINISH:
  - Apply two's-complement sign correction: negate the 64-bit product; negate quotient and remainder independently.
  - Write results: MUL gives HI = product[63:32], LO = product[31:0]. DIV gives LO = quotient, HI = remainder.
  - Return to IDLE.
- Divide by zero: full 33-cycle sequence still runs; HI/LO left unchanged; done still pulses.
- 0x80000000 / -1 (DIV): LO=0x80000000, HI=0; no exception.
- start while busy: ignored (upstream must stall). start in FINISH cycle: ignored.
- flush while in MUL/DIV/FINISH: state <= IDLE at next edge; HI/LO unchanged; done not asserted. flush in IDLE: no effect, and a coincident start is ignored.
- Simultaneous flush and rst_in: reset wins.

## Timing
- Accept edge N (IDLE, start=1, mul/div op).
- busy=1 in every cycle following edges N through N+32, i.e. 33 cycles (32 iteration cycles plus FINISH).
- HI/LO written at edge N+33; busy=0 and done=1 in the cycle following N+33; done low again after N+34.
- Mul/div latency: 33 cycles to new HI/LO visible. MTHI/MTLO latency: 1 cycle, with busy and done never asserted.
- A new start is accepted at edge N+33? No: N+33 is FINISH, so start is ignored there. Earliest back-to-back accept is edge N+34, giving an issue interval of 34 cycles.
- HI/LO are plain register outputs; no combinational path from inputs to outputs.
- busy is registered; it rises the cycle after the accept edge. Hazard logic must treat start itself as busy in the issue cycle.

## Test plan
- MULT RD1=0xFFFFFFFD (-3), RD2=7 -> busy 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulse 1 cycle.
- MULTU RD1=RD2=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MULT with the same operands -> HI=0, LO=1.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=0x0000000E, HI=0x00000002. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV with RD2=0, after MTHI 0x1234 and MTLO 0x5678 -> HI=0x1234, LO=0x5678 unchanged after 33 cycles; done pulses.
- MULT started, flush at 10th busy cycle -> busy=0 next cycle, HI/LO hold prior values, no done. Start asserted during busy is ignored with no result change.
- rst_in pulsed mid-DIV (asynchronous, between edges) -> HI=LO=0, busy=0 immediately. Back-to-back MTHI 0xAAAA then MTLO 0x5555 on consecutive cycles -> HI=0xAAAA, then LO=0x5555 on successive edges.
